// File: rtl/iob_reg_file_mp.sv
// iob_reg_file_mp
//   Multi-port flop-based register file. Each of N_WR write ports has one write
//   enable per column. Each of N_RD read ports has its own enable, and its read
//   data is registered. All entries and all read registers clear on an async
//   reset (rst_n low) or on a synchronous clr pulse.
//
//   Optional feature macro: IOB_REG_FILE_MP_BYPASS_EN
//     defined   - write-through read. A read of an entry that is being written
//                 in the same cycle returns the new column data.
//     undefined - read-first. A read returns the data stored before the edge.
//
// Ports (port k of a packed vector occupies slice [k*W +: W])
//   clk    in   1                  rising-edge clock
//   rst_n  in   1                  asynchronous active-low reset
//   clr    in   1                  synchronous clear of all entries and rdata
//   we     in   N_WR*NUM_COL       per-port, per-column write enables
//   waddr  in   N_WR*ADDR_W        write addresses
//   wdata  in   N_WR*DATA_W        write data
//   re     in   N_RD               read enables
//   raddr  in   N_RD*ADDR_W        read addresses
//   rdata  out  N_RD*DATA_W        registered read data
module iob_reg_file_mp #(
  parameter int NUM_COL = 2,
  parameter int COL_W   = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int N_WR    = 2,
  parameter int N_RD    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [N_WR*NUM_COL-1:0]       we,
  input  logic [N_WR*ADDR_W-1:0]        waddr,
  input  logic [N_WR*NUM_COL*COL_W-1:0] wdata,
  input  logic [N_RD-1:0]               re,
  input  logic [N_RD*ADDR_W-1:0]        raddr,
  output logic [N_RD*NUM_COL*COL_W-1:0] rdata
);

  localparam int DATA_W = NUM_COL * COL_W;

  logic [DATA_W-1:0]      mem_q  [DEPTH];
  logic [DATA_W-1:0]      mem_d  [DEPTH];
  logic [DATA_W-1:0]      mem_wr [DEPTH];
  logic [DATA_W-1:0]      rd_word [N_RD];
  logic [N_RD*DATA_W-1:0] rdata_q;
  logic [N_RD*DATA_W-1:0] rdata_d;

  assign rdata = rdata_q;

  // Merge all write ports into the storage image. Ports are applied in
  // ascending order, so the highest port index wins each column on a
  // collision. An address at or above DEPTH never matches an entry, so that
  // write is dropped.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_wr[e] = mem_q[e];
    end
    for (int k = 0; k < N_WR; k++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (we[k*NUM_COL+c]) begin
          for (int e = 0; e < DEPTH; e++) begin
            if (waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
              mem_wr[e][c*COL_W +: COL_W] = wdata[k*DATA_W + c*COL_W +: COL_W];
            end
          end
        end
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = clr ? '0 : mem_wr[e];
    end
  end

  // Read mux. An out-of-range address matches no entry and returns zero.
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      rd_word[j] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (raddr[j*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
`ifdef IOB_REG_FILE_MP_BYPASS_EN
          rd_word[j] = mem_wr[e];
`else
          rd_word[j] = mem_q[e];
`endif
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    for (int j = 0; j < N_RD; j++) begin
      if (clr) begin
        rdata_d[j*DATA_W +: DATA_W] = '0;
      end else if (re[j]) begin
        rdata_d[j*DATA_W +: DATA_W] = rd_word[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      rdata_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_iob_reg_file_mp.sv
module tb_iob_reg_file_mp;
  localparam int NUM_COL = 2;
  localparam int COL_W   = 4;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 12;
  localparam int N_WR    = 2;
  localparam int N_RD    = 2;
  localparam int DATA_W  = NUM_COL * COL_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     clr;
  logic [N_WR*NUM_COL-1:0]  we;
  logic [N_WR*ADDR_W-1:0]   waddr;
  logic [N_WR*DATA_W-1:0]   wdata;
  logic [N_RD-1:0]          re;
  logic [N_RD*ADDR_W-1:0]   raddr;
  logic [N_RD*DATA_W-1:0]   rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model [DEPTH];

  iob_reg_file_mp #(
    .NUM_COL(NUM_COL), .COL_W(COL_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .N_WR(N_WR), .N_RD(N_RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_port(input int j);
    return rdata[j*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    clr   = 1'b0;
    we    = '0;
    waddr = '0;
    wdata = '0;
    re    = '0;
    raddr = '0;
  endtask

  // Drive one write port; the model follows the same call order, so a later
  // (higher) port overrides an earlier one per column.
  task automatic set_wr(input int k, input logic [3:0] a, input logic [7:0] d,
                        input logic [1:0] e);
    we[k*NUM_COL +: NUM_COL]  = e;
    waddr[k*ADDR_W +: ADDR_W] = a;
    wdata[k*DATA_W +: DATA_W] = d;
    if (int'(a) < DEPTH) begin
      if (e[0]) model[a][3:0] = d[3:0];
      if (e[1]) model[a][7:4] = d[7:4];
    end
  endtask

  task automatic set_rd(input int j, input logic [3:0] a);
    re[j] = 1'b1;
    raddr[j*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  initial begin
    idle();
    clear_model();
    rst_n = 1'b0;
    #2;
    chk("reset_rd0", rd_port(0), 8'h00);
    chk("reset_rd1", rd_port(1), 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reads before any write return zero.
    set_rd(0, 4'd0);
    set_rd(1, 4'd11);
    step();
    chk("empty_rd0", rd_port(0), 8'h00);
    chk("empty_rd1", rd_port(1), 8'h00);

    // Fill and read back.
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(0, 4'(i), 8'(i), 2'b11);
      step();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(1, 4'(i));
      step();
      chk($sformatf("fill_rd%0d", i), rd_port(1), 8'(i));
    end

    // Column enables.
    set_wr(0, 4'd3, 8'hAB, 2'b11);
    step();
    set_wr(0, 4'd3, 8'hCD, 2'b01);
    step();
    set_rd(0, 4'd3);
    step();
    chk("col_en", rd_port(0), 8'hAD);

    // Collision priority.
    set_wr(0, 4'd5, 8'h11, 2'b11);
    set_wr(1, 4'd5, 8'h22, 2'b11);
    step();
    set_rd(0, 4'd5);
    step();
    chk("coll_full", rd_port(0), 8'h22);
    set_wr(0, 4'd5, 8'h33, 2'b10);
    set_wr(1, 4'd5, 8'h44, 2'b01);
    step();
    set_rd(1, 4'd5);
    step();
    chk("coll_merge", rd_port(1), 8'h34);

    // Out-of-range write changes nothing.
    set_wr(0, 4'd13, 8'hFF, 2'b11);
    step();
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_rd(0, 4'(i));
      set_rd(1, 4'(i + DEPTH / 2));
      step();
      chk($sformatf("oor_wr_e%0d", i), rd_port(0), model[i]);
      chk($sformatf("oor_wr_e%0d", i + DEPTH / 2), rd_port(1), model[i + DEPTH / 2]);
    end

    // Out-of-range read returns zero (port0 holds a nonzero value first).
    set_rd(0, 4'd13);
    step();
    chk("oor_rd", rd_port(0), 8'h00);

    // Hold with re low.
    set_rd(0, 4'd5);
    step();
    chk("hold_load", rd_port(0), 8'h34);
    for (int i = 0; i < 3; i++) begin
      raddr[3:0] = 4'd3;
      step();
      chk($sformatf("hold_c%0d", i), rd_port(0), 8'h34);
    end

    // clr overrides a write and a read in the same cycle.
    set_rd(1, 4'd5);
    step();
    chk("pre_clr", rd_port(1), 8'h34);
    clr = 1'b1;
    set_wr(0, 4'd2, 8'h77, 2'b11);
    set_rd(0, 4'd5);
    step();
    clear_model();
    chk("clr_rd0", rd_port(0), 8'h00);
    chk("clr_rd1", rd_port(1), 8'h00);
    set_rd(0, 4'd2);
    set_rd(1, 4'd5);
    step();
    chk("clr_a2", rd_port(0), 8'h00);
    chk("clr_a5", rd_port(1), 8'h00);

    // Async reset mid-fill.
    set_wr(0, 4'd0, 8'h5A, 2'b11);
    step();
    set_rd(1, 4'd0);
    step();
    chk("pre_rst", rd_port(1), 8'h5A);
    set_wr(0, 4'd1, 8'h66, 2'b11);
    set_rd(1, 4'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", rd_port(1), 8'h00);
    @(posedge clk);
    #1 chk("rst_hold", rd_port(1), 8'h00);
    idle();
    clear_model();
    rst_n = 1'b1;
    set_rd(0, 4'd0);
    set_rd(1, 4'd1);
    step();
    chk("post_rst_a0", rd_port(0), 8'h00);
    chk("post_rst_a1", rd_port(1), 8'h00);

    // Same-cycle read/write of one entry.
    set_wr(0, 4'd7, 8'h12, 2'b11);
    step();
    set_wr(0, 4'd7, 8'h9C, 2'b11);
    set_rd(1, 4'd7);
    step();
`ifdef IOB_REG_FILE_MP_BYPASS_EN
    chk("rw_same", rd_port(1), 8'h9C);
`else
    chk("rw_same", rd_port(1), 8'h12);
`endif
    set_rd(1, 4'd7);
    step();
    chk("rw_next", rd_port(1), 8'h9C);

    set_wr(0, 4'd7, 8'h12, 2'b11);
    step();
    set_wr(0, 4'd7, 8'h9C, 2'b01);
    set_rd(0, 4'd7);
    step();
`ifdef IOB_REG_FILE_MP_BYPASS_EN
    chk("rw_col", rd_port(0), 8'h1C);
`else
    chk("rw_col", rd_port(0), 8'h12);
`endif
    set_rd(0, 4'd7);
    step();
    chk("rw_col_next", rd_port(0), 8'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
